// File: rtl/iob_ram_2p_be.sv
// ---------------------------------------------------------------------------
// iob_ram_2p_be
//
// Single-clock simple dual-port RAM with per-byte write strobes, a registered
// and flagged read path of 1 or 2 cycles latency, and optional forwarding of
// write data onto a read that hits the same address on the same edge.
// Used as packet-buffer and descriptor-table storage in the Ethernet datapath.
//
// Parameters
//   DATA_W   : word width in bits (multiple of 8)
//   ADDR_W   : address width, depth = 2**ADDR_W words
//   READ_LAT : read latency in enabled clock edges, 1 or 2 (any value other
//              than 2 builds the 1-cycle path)
//   BYPASS   : 1 = a same-edge read/write collision returns the merged new
//              word, 0 = it returns the old word
//
// Ports
//   clk_i     : clock, rising edge
//   arst_n_i  : asynchronous reset, active low (clears read path, not memory)
//   cke_i     : clock enable, low freezes memory, pipeline and outputs
//   w_en_i    : write request
//   w_strb_i  : byte write strobes, bit k covers data bits [8k+7:8k]
//   w_addr_i  : write address
//   w_data_i  : write data
//   r_en_i    : read request
//   r_addr_i  : read address
//   r_data_o  : read data, holds the last result between reads
//   r_valid_o : one-cycle pulse when r_data_o carries a new result
// ---------------------------------------------------------------------------
module iob_ram_2p_be #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int READ_LAT = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                w_en_i,
  input  logic [DATA_W/8-1:0] w_strb_i,
  input  logic [ADDR_W-1:0]   w_addr_i,
  input  logic [DATA_W-1:0]   w_data_i,
  input  logic                r_en_i,
  input  logic [ADDR_W-1:0]   r_addr_i,
  output logic [DATA_W-1:0]   r_data_o,
  output logic                r_valid_o
);

  localparam int BYTE_W    = 32'sd8;
  localparam int STRB_W    = DATA_W / BYTE_W;
  localparam int DEPTH     = 32'sd1 << ADDR_W;
  localparam bit BYPASS_EN = (BYPASS != 32'sd0);
  localparam bit LAT2_EN   = (READ_LAT == 32'sd2);

  // Replace the strobed bytes of old_word with the matching bytes of new_word.
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb[k]) begin
        res[k*BYTE_W +: BYTE_W] = new_word[k*BYTE_W +: BYTE_W];
      end else begin
        res[k*BYTE_W +: BYTE_W] = old_word[k*BYTE_W +: BYTE_W];
      end
    end
    return res;
  endfunction

  // Storage array; contents are undefined after power-up on purpose.
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Read-port combinational signals.
  logic [DATA_W-1:0] mem_word_s;
  logic              collide_s;
  logic [DATA_W-1:0] rd_word_s;

  // Sample stage: the word captured on the edge that accepts the read.
  logic              samp_vld_r;
  logic [DATA_W-1:0] samp_word_r;

  // Final-stage inputs feeding the output register.
  logic              fin_vld_s;
  logic [DATA_W-1:0] fin_word_s;

  // Byte-strobed write into the array; storage is never reset.
  always_ff @(posedge clk_i) begin
    if (cke_i && w_en_i) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (w_strb_i[k]) begin
          mem_r[w_addr_i][k*BYTE_W +: BYTE_W] <= w_data_i[k*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Select the word a read takes: array contents, or the merged write word on
  // a bypassed same-address collision. Without bypass the old word is used,
  // because the array update only lands at the end of the same edge.
  always_comb begin
    mem_word_s = mem_r[r_addr_i];
    collide_s  = 1'b0;
    rd_word_s  = mem_word_s;
    if (w_en_i && (w_addr_i == r_addr_i)) begin
      collide_s = 1'b1;
    end else begin
      collide_s = 1'b0;
    end
    if (BYPASS_EN && collide_s) begin
      rd_word_s = byte_merge(mem_word_s, w_data_i, w_strb_i);
    end else begin
      rd_word_s = mem_word_s;
    end
  end

  // Sample stage: capture the read word on the accepting edge, so a write on
  // any later edge cannot disturb a read already issued.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      samp_vld_r  <= 1'b0;
      samp_word_r <= {DATA_W{1'b0}};
    end else if (cke_i) begin
      samp_vld_r <= r_en_i;
      if (r_en_i) begin
        samp_word_r <= rd_word_s;
      end
    end
  end

  generate
    if (LAT2_EN) begin : g_lat2
      logic              mid_vld_r;
      logic [DATA_W-1:0] mid_word_r;

      // Extra stage for 2-cycle latency: a registered copy of the sample stage.
      always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
          mid_vld_r  <= 1'b0;
          mid_word_r <= {DATA_W{1'b0}};
        end else if (cke_i) begin
          mid_vld_r <= samp_vld_r;
          if (samp_vld_r) begin
            mid_word_r <= samp_word_r;
          end
        end
      end

      assign fin_vld_s  = mid_vld_r;
      assign fin_word_s = mid_word_r;
    end else begin : g_lat1
      assign fin_vld_s  = samp_vld_r;
      assign fin_word_s = samp_word_r;
    end
  endgenerate

  // Output register: data loads only for a completing read, so it holds the
  // last result; the valid flag is the final valid bit of the pipeline.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_valid_o <= 1'b0;
      r_data_o  <= {DATA_W{1'b0}};
    end else if (cke_i) begin
      r_valid_o <= fin_vld_s;
      if (fin_vld_s) begin
        r_data_o <= fin_word_s;
      end
    end
  end

endmodule

// File: tb/tb_iob_ram_2p_be.sv
// ---------------------------------------------------------------------------
// tb_iob_ram_2p_be
//
// Two instances share one stimulus: dut_a (READ_LAT=1, BYPASS=1) and
// dut_b (READ_LAT=2, BYPASS=0). A table of hand-derived vectors, a few
// directed multi-cycle sequences and a randomized phase are checked; a
// behavioural model (word array plus per-byte "known" mask and a list of
// pending reads with due times) is compared against both outputs on every
// falling edge.
// ---------------------------------------------------------------------------
module tb_iob_ram_2p_be;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int LAT_A = 1;
  localparam int BYP_A = 1;
  localparam int LAT_B = 2;
  localparam int BYP_B = 0;

  logic          clk;
  logic          arst_n;
  logic          cke;
  logic          w_en;
  logic [3:0]    w_strb;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          r_en;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] a_data;
  logic          a_valid;
  logic [DW-1:0] b_data;
  logic          b_valid;

  int n_cmp;
  int n_fail;

  iob_ram_2p_be #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(LAT_A), .BYPASS(BYP_A)) dut_a (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
    .w_en_i(w_en), .w_strb_i(w_strb), .w_addr_i(w_addr), .w_data_i(w_data),
    .r_en_i(r_en), .r_addr_i(r_addr), .r_data_o(a_data), .r_valid_o(a_valid)
  );

  iob_ram_2p_be #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(LAT_B), .BYPASS(BYP_B)) dut_b (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
    .w_en_i(w_en), .w_strb_i(w_strb), .w_addr_i(w_addr), .w_data_i(w_data),
    .r_en_i(r_en), .r_addr_i(r_addr), .r_data_o(b_data), .r_valid_o(b_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ----------------------------------------------------------------- model
  typedef struct {
    int          dut;
    int          due;
    logic [31:0] data;
    logic [31:0] mask;
  } pend_t;

  logic [31:0] m_mem   [64];
  logic [31:0] m_known [64];
  pend_t       pend_q  [$];
  int          m_lat   [2];
  bit          m_byp   [2];
  logic        m_vld   [2];
  logic [31:0] m_data  [2];
  logic [31:0] m_mask  [2];
  int          cnt;

  task automatic model_step();
    logic [31:0] word;
    logic [31:0] mask;
    if (!arst_n) begin
      pend_q.delete();
      for (int d = 0; d < 2; d++) begin
        m_vld[d]  = 1'b0;
        m_data[d] = 32'h0;
        m_mask[d] = 32'hFFFF_FFFF;
      end
    end else if (cke) begin
      cnt = cnt + 1;
      for (int d = 0; d < 2; d++) m_vld[d] = 1'b0;
      for (int i = pend_q.size() - 1; i >= 0; i--) begin
        if (pend_q[i].due == cnt) begin
          m_vld[pend_q[i].dut]  = 1'b1;
          m_data[pend_q[i].dut] = pend_q[i].data;
          m_mask[pend_q[i].dut] = pend_q[i].mask;
          pend_q.delete(i);
        end
      end
      if (r_en) begin
        for (int d = 0; d < 2; d++) begin
          word = m_mem[r_addr];
          mask = m_known[r_addr];
          if (m_byp[d] && w_en && (w_addr == r_addr)) begin
            for (int k = 0; k < 4; k++) begin
              if (w_strb[k]) begin
                word[8*k +: 8] = w_data[8*k +: 8];
                mask[8*k +: 8] = 8'hFF;
              end
            end
          end
          pend_q.push_back('{d, cnt + m_lat[d], word, mask});
        end
      end
      if (w_en) begin
        for (int k = 0; k < 4; k++) begin
          if (w_strb[k]) begin
            m_mem[w_addr][8*k +: 8]   = w_data[8*k +: 8];
            m_known[w_addr][8*k +: 8] = 8'hFF;
          end
        end
      end
    end
  endtask

  initial begin
    cnt = 0;
    m_lat[0] = LAT_A; m_byp[0] = (BYP_A != 0);
    m_lat[1] = LAT_B; m_byp[1] = (BYP_B != 0);
    for (int i = 0; i < 64; i++) begin
      m_mem[i]   = 32'h0;
      m_known[i] = 32'h0;
    end
    for (int d = 0; d < 2; d++) begin
      m_vld[d]  = 1'b0;
      m_data[d] = 32'h0;
      m_mask[d] = 32'hFFFF_FFFF;
    end
    forever begin
      @(posedge clk or negedge arst_n);
      model_step();
    end
  end

  // Scoreboard comparison on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("sb_a_valid", 32'(a_valid), 32'(m_vld[0]));
      check("sb_a_data", a_data & m_mask[0], m_data[0] & m_mask[0]);
      check("sb_b_valid", 32'(b_valid), 32'(m_vld[1]));
      check("sb_b_data", b_data & m_mask[1], m_data[1] & m_mask[1]);
    end
  end

  // ---------------------------------------------------------------- stimulus
  typedef struct {
    logic        w_en;
    logic [3:0]  strb;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic        r_en;
    logic [5:0]  raddr;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [13];

  task automatic drive_idle();
    cke  = 1'b1;
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  task automatic drive_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    w_en = 1'b1; w_addr = a; w_data = d; w_strb = s;
  endtask

  task automatic drive_rd(input logic [5:0] a);
    r_en = 1'b1; r_addr = a;
  endtask

  // Apply one vector alone; caller is at a falling edge.
  task automatic apply_vec(input int idx, input vec_t v);
    cke = 1'b1; w_en = v.w_en; w_strb = v.strb; w_addr = v.waddr; w_data = v.wdata;
    r_en = v.r_en; r_addr = v.raddr;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    check($sformatf("vec%0d_a_valid", idx), 32'(a_valid), 32'(v.r_en));
    if (v.r_en) check($sformatf("vec%0d_a_data", idx), a_data, v.exp_a);
    check($sformatf("vec%0d_b_early", idx), 32'(b_valid), 32'h0);
    @(negedge clk);
    check($sformatf("vec%0d_a_pulse", idx), 32'(a_valid), 32'h0);
    check($sformatf("vec%0d_b_valid", idx), 32'(b_valid), 32'(v.r_en));
    if (v.r_en) check($sformatf("vec%0d_b_data", idx), b_data, v.exp_b);
  endtask

  initial begin
    vec_t rv;
    logic exp_v;
    n_cmp = 0; n_fail = 0;
    arst_n = 1'b1;
    w_strb = 4'h0; w_addr = 6'd0; w_data = 32'h0; r_addr = 6'd0;
    drive_idle();

    //             w_en  strb   waddr   wdata          r_en  raddr   exp_a          exp_b
    vecs[0]  = '{1'b1, 4'hF, 6'd5,  32'hDEADBEEF, 1'b0, 6'd0,  32'h0,         32'h0};
    vecs[1]  = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b1, 6'd5,  32'hDEADBEEF,  32'hDEADBEEF};
    vecs[2]  = '{1'b1, 4'hF, 6'd3,  32'h11223344, 1'b0, 6'd0,  32'h0,         32'h0};
    vecs[3]  = '{1'b1, 4'h5, 6'd3,  32'hAABBCCDD, 1'b0, 6'd0,  32'h0,         32'h0};
    vecs[4]  = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b1, 6'd3,  32'h11BB33DD,  32'h11BB33DD};
    vecs[5]  = '{1'b1, 4'hF, 6'd7,  32'h00000000, 1'b0, 6'd0,  32'h0,         32'h0};
    vecs[6]  = '{1'b1, 4'h3, 6'd7,  32'hFFFFFFFF, 1'b1, 6'd7,  32'h0000FFFF,  32'h00000000};
    vecs[7]  = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b1, 6'd7,  32'h0000FFFF,  32'h0000FFFF};
    vecs[8]  = '{1'b1, 4'h0, 6'd3,  32'hFFFFFFFF, 1'b0, 6'd0,  32'h0,         32'h0};
    vecs[9]  = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b1, 6'd3,  32'h11BB33DD,  32'h11BB33DD};
    vecs[10] = '{1'b1, 4'hF, 6'd63, 32'hCAFEF00D, 1'b0, 6'd0,  32'h0,         32'h0};
    vecs[11] = '{1'b1, 4'hC, 6'd63, 32'h99999999, 1'b1, 6'd63, 32'h9999F00D,  32'hCAFEF00D};
    vecs[12] = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b1, 6'd63, 32'h9999F00D,  32'h9999F00D};

    // Reset held: outputs cleared.
    #1 arst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_a_valid", 32'(a_valid), 32'h0);
      check("rst_a_data", a_data, 32'h0);
      check("rst_b_valid", 32'(b_valid), 32'h0);
      check("rst_b_data", b_data, 32'h0);
    end
    arst_n = 1'b1;

    for (int i = 0; i < 13; i++) apply_vec(i, vecs[i]);

    // Write, read on the next edge, then overwrite on the edge after the read.
    drive_wr(6'd9, 32'h0BADCAFE, 4'hF);
    @(negedge clk);
    w_en = 1'b0; drive_rd(6'd9);
    @(negedge clk);
    r_en = 1'b0; drive_wr(6'd9, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    check("raw_a_valid", 32'(a_valid), 32'h1);
    check("raw_a_data", a_data, 32'h0BADCAFE);
    drive_idle();
    @(negedge clk);
    check("raw_b_valid", 32'(b_valid), 32'h1);
    check("raw_b_data", b_data, 32'h0BADCAFE);

    // Streaming: fill 0..7, then 8 back-to-back reads.
    for (int i = 0; i < 8; i++) begin
      drive_wr(6'(i), 32'h100 + 32'(i), 4'hF);
      @(negedge clk);
    end
    w_en = 1'b0;
    drive_rd(6'd0);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      exp_v = (k >= 1) && (k <= 8);
      check($sformatf("stream%0d_a_valid", k), 32'(a_valid), 32'(exp_v));
      if (exp_v) check($sformatf("stream%0d_a_data", k), a_data, 32'h100 + 32'(k - 1));
      exp_v = (k >= 2) && (k <= 9);
      check($sformatf("stream%0d_b_valid", k), 32'(b_valid), 32'(exp_v));
      if (exp_v) check($sformatf("stream%0d_b_data", k), b_data, 32'h100 + 32'(k - 2));
      if (k + 1 < 8) drive_rd(6'(k + 1));
      else r_en = 1'b0;
    end

    // Clock enable: a read stalls while cke is low; a write then is ignored.
    drive_rd(6'd9);
    @(negedge clk);
    check("cke_a_wait0", 32'(a_valid), 32'h0);
    cke = 1'b0;
    drive_wr(6'd9, 32'h00000000, 4'hF);
    drive_rd(6'd9);
    repeat (3) begin
      @(negedge clk);
      check("cke_a_held", 32'(a_valid), 32'h0);
      check("cke_b_held", 32'(b_valid), 32'h0);
    end
    drive_idle();
    @(negedge clk);
    check("cke_a_valid", 32'(a_valid), 32'h1);
    check("cke_a_data", a_data, 32'hFFFFFFFF);
    check("cke_b_wait", 32'(b_valid), 32'h0);
    @(negedge clk);
    check("cke_a_pulse", 32'(a_valid), 32'h0);
    check("cke_b_valid", 32'(b_valid), 32'h1);
    check("cke_b_data", b_data, 32'hFFFFFFFF);
    rv = '{1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd9, 32'hFFFFFFFF, 32'hFFFFFFFF};
    apply_vec(100, rv);

    // Reset pulse with reads in flight.
    drive_rd(6'd63);
    @(negedge clk);
    drive_rd(6'd6);
    @(negedge clk);
    drive_idle();
    #1 arst_n = 1'b0;
    #1 arst_n = 1'b1;
    check("mrst_a_valid", 32'(a_valid), 32'h0);
    check("mrst_a_data", a_data, 32'h0);
    check("mrst_b_valid", 32'(b_valid), 32'h0);
    check("mrst_b_data", b_data, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("mrst_a_quiet", 32'(a_valid), 32'h0);
      check("mrst_a_zero", a_data, 32'h0);
      check("mrst_b_quiet", 32'(b_valid), 32'h0);
      check("mrst_b_zero", b_data, 32'h0);
    end
    rv = '{1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd63, 32'h9999F00D, 32'h9999F00D};
    apply_vec(101, rv);
    rv = '{1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd6, 32'h00000106, 32'h00000106};
    apply_vec(102, rv);

    // Randomized traffic, checked by the model on every falling edge.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        #1 arst_n = 1'b0;
        #1 arst_n = 1'b1;
      end
      cke    = ($urandom_range(0, 9) != 0);
      w_en   = ($urandom_range(0, 1) == 1);
      r_en   = ($urandom_range(0, 2) != 0);
      w_strb = 4'($urandom_range(0, 15));
      w_data = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        w_addr = 6'($urandom_range(0, 63));
        r_addr = 6'($urandom_range(0, 63));
      end else begin
        w_addr = 6'($urandom_range(0, 7));
        r_addr = 6'($urandom_range(0, 7));
      end
      @(negedge clk);
    end
    drive_idle();
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
